// File: rtl/pipeline_mem_stage.sv
// RV64 memory-access stage: aligned load/store over a req/ready port,
// with lane steering, load extension and MEM-stage result registers.
module pipeline_mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [63:0] pc_EXA,
  input  logic [63:0] alu_result_EXA,
  input  logic [63:0] reg_data2_EXA,
  input  logic [4:0]  rd_EXA,
  input  logic        rf_wr_en_EXA,
  input  logic [1:0]  rf_wr_sel_EXA,
  input  logic [2:0]  dm_rd_ctrl_EXA,
  input  logic [2:0]  dm_wr_ctrl_EXA,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [63:0] mem_rdata,
  output logic        mem_stall,
  output logic [63:0] pc_MEM,
  output logic [63:0] alu_result_MEM,
  output logic [63:0] dm_rdata_MEM,
  output logic [4:0]  rd_MEM,
  output logic        rf_wr_en_MEM,
  output logic [1:0]  rf_wr_sel_MEM,
  output logic        misalign_MEM
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  off;
  logic [1:0]  size;
  logic        is_store, is_load, access;
  logic        misalign, go, capture;
  logic [7:0]  strb;
  logic [63:0] sh, ld_ext, ld_val, hold;

  assign off      = alu_result_EXA[2:0];
  assign is_store = (dm_wr_ctrl_EXA != 3'd0) &&
                    (dm_wr_ctrl_EXA <= 3'd4);
  assign is_load  = !is_store && (dm_rd_ctrl_EXA != 3'd0);
  assign access   = is_store || is_load;

  // size: 0 byte, 1 half, 2 word, 3 double
  always_comb begin
    size = 2'd0;
    if (is_store) begin
      case (dm_wr_ctrl_EXA)
        3'd2:    size = 2'd1;
        3'd3:    size = 2'd2;
        3'd4:    size = 2'd3;
        default: size = 2'd0;
      endcase
    end else begin
      case (dm_rd_ctrl_EXA)
        3'd3, 3'd4: size = 2'd1;
        3'd5, 3'd6: size = 2'd2;
        3'd7:       size = 2'd3;
        default:    size = 2'd0;
      endcase
    end
  end

  always_comb begin
    misalign = 1'b0;
    strb     = 8'h01;
    case (size)
      2'd1: begin
        misalign = off[0];
        strb     = 8'h03;
      end
      2'd2: begin
        misalign = |off[1:0];
        strb     = 8'h0F;
      end
      2'd3: begin
        misalign = |off;
        strb     = 8'hFF;
      end
      default: begin
        misalign = 1'b0;
        strb     = 8'h01;
      end
    endcase
  end

  assign go = access && !misalign;

  assign mem_we    = is_store;
  assign mem_addr  = {alu_result_EXA[63:3], 3'b000};
  assign mem_wdata = reg_data2_EXA << {off, 3'b000};
  assign mem_wstrb = is_store ? (strb << off) : 8'h00;

  assign sh = mem_rdata >> {off, 3'b000};

  always_comb begin
    ld_ext = sh;
    case (dm_rd_ctrl_EXA)
      3'd1:    ld_ext = {{56{sh[7]}}, sh[7:0]};
      3'd2:    ld_ext = {56'd0, sh[7:0]};
      3'd3:    ld_ext = {{48{sh[15]}}, sh[15:0]};
      3'd4:    ld_ext = {48'd0, sh[15:0]};
      3'd5:    ld_ext = {{32{sh[31]}}, sh[31:0]};
      3'd6:    ld_ext = {32'd0, sh[31:0]};
      default: ld_ext = sh;
    endcase
  end

  assign ld_val = (is_load && !misalign) ? ld_ext : 64'd0;

  // Ready under an external stall parks the data in hold until release
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_stall = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          mem_req = 1'b1;
          if (!mem_ready) begin
            mem_stall = 1'b1;
            state_nxt = WAIT;
          end else if (stall) begin
            capture   = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      WAIT: begin
        mem_req = 1'b1;
        if (!mem_ready) begin
          mem_stall = 1'b1;
        end else if (stall) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = IDLE;
        end
      end
      DONE: begin
        if (!stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!reset) begin
      mem_req   = 1'b0;
      mem_stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      hold           <= 64'd0;
      pc_MEM         <= 64'd0;
      alu_result_MEM <= 64'd0;
      dm_rdata_MEM   <= 64'd0;
      rd_MEM         <= 5'd0;
      rf_wr_en_MEM   <= 1'b0;
      rf_wr_sel_MEM  <= 2'd0;
      misalign_MEM   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) hold <= ld_val;
      if (!stall) begin
        pc_MEM         <= pc_EXA;
        alu_result_MEM <= alu_result_EXA;
        rf_wr_sel_MEM  <= rf_wr_sel_EXA;
        if (mem_stall) begin
          dm_rdata_MEM <= 64'd0;
          rd_MEM       <= 5'd0;
          rf_wr_en_MEM <= 1'b0;
          misalign_MEM <= 1'b0;
        end else begin
          dm_rdata_MEM <= (state == DONE) ? hold : ld_val;
          rd_MEM       <= rd_EXA;
          rf_wr_en_MEM <= rf_wr_en_EXA && !(access && misalign);
          misalign_MEM <= access && misalign;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Self-checking bench for pipeline_mem_stage: directed scenarios
// plus randomized accesses against a byte-level reference model.
module tb_pipeline_mem_stage;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [63:0] pc_EXA, alu_result_EXA, reg_data2_EXA;
  logic [4:0]  rd_EXA;
  logic        rf_wr_en_EXA;
  logic [1:0]  rf_wr_sel_EXA;
  logic [2:0]  dm_rd_ctrl_EXA, dm_wr_ctrl_EXA;
  logic        mem_req, mem_we, mem_ready, mem_stall;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wstrb;
  logic [63:0] pc_MEM, alu_result_MEM, dm_rdata_MEM;
  logic [4:0]  rd_MEM;
  logic        rf_wr_en_MEM, misalign_MEM;
  logic [1:0]  rf_wr_sel_MEM;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipeline_mem_stage dut (
    .clk(clk), .reset(reset), .stall(stall),
    .pc_EXA(pc_EXA), .alu_result_EXA(alu_result_EXA),
    .reg_data2_EXA(reg_data2_EXA), .rd_EXA(rd_EXA),
    .rf_wr_en_EXA(rf_wr_en_EXA), .rf_wr_sel_EXA(rf_wr_sel_EXA),
    .dm_rd_ctrl_EXA(dm_rd_ctrl_EXA), .dm_wr_ctrl_EXA(dm_wr_ctrl_EXA),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_stall(mem_stall), .pc_MEM(pc_MEM),
    .alu_result_MEM(alu_result_MEM), .dm_rdata_MEM(dm_rdata_MEM),
    .rd_MEM(rd_MEM), .rf_wr_en_MEM(rf_wr_en_MEM),
    .rf_wr_sel_MEM(rf_wr_sel_MEM), .misalign_MEM(misalign_MEM)
  );

  function automatic int ld_bytes(input logic [2:0] c);
    case (c)
      3'd1, 3'd2: return 1;
      3'd3, 3'd4: return 2;
      3'd5, 3'd6: return 4;
      3'd7:       return 8;
      default:    return 0;
    endcase
  endfunction

  function automatic int st_bytes(input logic [2:0] c);
    case (c)
      3'd1:    return 1;
      3'd2:    return 2;
      3'd3:    return 4;
      3'd4:    return 8;
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] ref_load(input logic [2:0] c,
    input logic [63:0] d, input int o);
    int n;
    logic [63:0] v;
    n = ld_bytes(c);
    v = 0;
    for (int i = 0; i < n; i++)
      v = v | (((d >> (8 * (o + i))) & 64'hFF) << (8 * i));
    if ((c == 1 || c == 3 || c == 5) && ((v >> (8 * n - 1)) & 1))
      v = v - (64'd1 << (8 * n));
    return v;
  endfunction

  function automatic logic [7:0] ref_strb(input int n, input int o);
    logic [7:0] s;
    s = 0;
    for (int i = 0; i < n; i++) s[o + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [63:0] d,
    input int o);
    logic [63:0] w;
    w = 0;
    for (int j = o; j < 8; j++)
      w = w | (((d >> (8 * (j - o))) & 64'hFF) << (8 * j));
    return w;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop;
    pc_EXA = 0; alu_result_EXA = 0; reg_data2_EXA = 0;
    rd_EXA = 0; rf_wr_en_EXA = 0; rf_wr_sel_EXA = 0;
    dm_rd_ctrl_EXA = 0; dm_wr_ctrl_EXA = 0;
  endtask

  task automatic set_op(input logic [63:0] pc, input logic [63:0] a,
    input logic [63:0] d, input logic [4:0] rd, input logic we,
    input logic [2:0] rc, input logic [2:0] wc);
    pc_EXA = pc; alu_result_EXA = a; reg_data2_EXA = d;
    rd_EXA = rd; rf_wr_en_EXA = we; rf_wr_sel_EXA = 2'd1;
    dm_rd_ctrl_EXA = rc; dm_wr_ctrl_EXA = wc;
  endtask

  task automatic test_reset_init;
    reset = 0; stall = 0; mem_ready = 0; mem_rdata = 0;
    set_nop();
    tick(); tick();
    n_cmp++;
    if ({pc_MEM, alu_result_MEM, dm_rdata_MEM, rd_MEM, rf_wr_en_MEM,
         rf_wr_sel_MEM, misalign_MEM} !== '0) begin
      n_bad++;
      $display("FAIL reset_init_mem: got pc=%h alu=%h rd=%0d", pc_MEM,
               alu_result_MEM, rd_MEM);
    end
    n_cmp++;
    if (mem_req !== 1'b0 || mem_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_init_req: req=%b stall=%b want 0", mem_req,
               mem_stall);
    end
    reset = 1;
  endtask

  task automatic test_sb_zero_wait;
    set_op(64'h100, 64'h1003, 64'h1234_5678_9ABC_DEAB, 5'd0, 0, 0, 1);
    mem_ready = 1;
    #1;
    n_cmp++;
    if (mem_req !== 1 || mem_we !== 1 || mem_addr !== 64'h1000) begin
      n_bad++;
      $display("FAIL sb_req: req=%b we=%b addr=%h want 1 1 1000",
               mem_req, mem_we, mem_addr);
    end
    n_cmp++;
    if (mem_wstrb !== 8'h08 || mem_wdata[31:24] !== 8'hAB) begin
      n_bad++;
      $display("FAIL sb_lane: strb=%h byte3=%h want 08 ab", mem_wstrb,
               mem_wdata[31:24]);
    end
    n_cmp++;
    if (mem_stall !== 0) begin
      n_bad++;
      $display("FAIL sb_stall: got %b want 0", mem_stall);
    end
    tick();
    mem_ready = 0;
    set_nop();
    n_cmp++;
    if (alu_result_MEM !== 64'h1003 || pc_MEM !== 64'h100 ||
        dm_rdata_MEM !== 0) begin
      n_bad++;
      $display("FAIL sb_mem: alu=%h pc=%h dm=%h want 1003 100 0",
               alu_result_MEM, pc_MEM, dm_rdata_MEM);
    end
  endtask

  task automatic test_misaligned;
    set_op(64'h300, 64'h3002, 0, 5'd3, 1, 5, 0);
    mem_ready = 0;
    #1;
    n_cmp++;
    if (mem_req !== 0 || mem_stall !== 0) begin
      n_bad++;
      $display("FAIL mis_req: req=%b stall=%b want 0 0", mem_req,
               mem_stall);
    end
    tick();
    set_nop();
    n_cmp++;
    if (misalign_MEM !== 1 || rf_wr_en_MEM !== 0) begin
      n_bad++;
      $display("FAIL mis_mem: mis=%b wen=%b want 1 0", misalign_MEM,
               rf_wr_en_MEM);
    end
  endtask

  task automatic test_lh_wait(input bit uns);
    int scnt;
    logic [63:0] want;
    scnt = 0;
    want = uns ? 64'h8001 : 64'hFFFF_FFFF_FFFF_8001;
    set_op(64'h200, 64'h2006, 0, 5'd7, 1, uns ? 3'd4 : 3'd3, 0);
    mem_rdata = 64'h8001_0000_0000_0000;
    for (int c = 0; c <= 3; c++) begin
      mem_ready = (c == 3);
      #1;
      if (mem_stall === 1) scnt++;
      n_cmp++;
      if (mem_req !== 1) begin
        n_bad++;
        $display("FAIL lh_req c%0d: got %b want 1", c, mem_req);
      end
      tick();
      if (c < 3) begin
        n_cmp++;
        if (rd_MEM !== 0 || rf_wr_en_MEM !== 0 || misalign_MEM !== 0)
        begin
          n_bad++;
          $display("FAIL lh_bubble c%0d: rd=%0d wen=%b mis=%b", c,
                   rd_MEM, rf_wr_en_MEM, misalign_MEM);
        end
      end
    end
    mem_ready = 0;
    set_nop();
    n_cmp++;
    if (scnt != 3) begin
      n_bad++;
      $display("FAIL lh_stall_cycles: got %0d want 3", scnt);
    end
    n_cmp++;
    if (dm_rdata_MEM !== want || rd_MEM !== 7 || rf_wr_en_MEM !== 1)
    begin
      n_bad++;
      $display("FAIL lh_data uns=%0d: got %h rd=%0d want %h rd=7", uns,
               dm_rdata_MEM, rd_MEM, want);
    end
  endtask

  task automatic test_ready_during_stall;
    logic [63:0] d;
    d = {$urandom, $urandom};
    set_op(64'h500, 64'h5008, 0, 5'd9, 1, 7, 0);
    mem_ready = 0; stall = 0; mem_rdata = d;
    tick();
    stall = 1; mem_ready = 1;
    #1;
    n_cmp++;
    if (mem_stall !== 0 || mem_req !== 1) begin
      n_bad++;
      $display("FAIL rds_ready: stall=%b req=%b want 0 1", mem_stall,
               mem_req);
    end
    tick();
    mem_ready = 0; mem_rdata = ~d;
    #1;
    n_cmp++;
    if (mem_req !== 0 || mem_stall !== 0 || rd_MEM !== 0) begin
      n_bad++;
      $display("FAIL rds_done: req=%b stall=%b rd=%0d want 0 0 0",
               mem_req, mem_stall, rd_MEM);
    end
    tick();
    stall = 0;
    tick();
    set_nop();
    n_cmp++;
    if (dm_rdata_MEM !== d || rd_MEM !== 9 || rf_wr_en_MEM !== 1) begin
      n_bad++;
      $display("FAIL rds_data: got %h rd=%0d want %h rd=9",
               dm_rdata_MEM, rd_MEM, d);
    end
  endtask

  task automatic test_store_priority;
    logic [63:0] d;
    d = {$urandom, $urandom};
    set_op(64'h400, 64'h4000, d, 5'd0, 0, 5, 4);
    mem_ready = 1;
    #1;
    n_cmp++;
    if (mem_we !== 1 || mem_wstrb !== 8'hFF || mem_wdata !== d) begin
      n_bad++;
      $display("FAIL prio_req: we=%b strb=%h wdata=%h want 1 ff %h",
               mem_we, mem_wstrb, mem_wdata, d);
    end
    tick();
    mem_ready = 0;
    set_nop();
    n_cmp++;
    if (dm_rdata_MEM !== 0) begin
      n_bad++;
      $display("FAIL prio_dm: got %h want 0", dm_rdata_MEM);
    end
  endtask

  task automatic test_random;
    for (int t = 0; t < 60; t++) begin
      logic [2:0] rc, wc;
      logic [63:0] a, d, rdat, pc;
      logic [4:0] rd;
      logic we, st, ld, mis;
      int o, n, nw, scnt;
      rc = $urandom_range(0, 7);
      wc = $urandom_range(0, 7);
      o = $urandom_range(0, 7);
      a = {$urandom, $urandom};
      a[2:0] = o[2:0];
      d = {$urandom, $urandom};
      rdat = {$urandom, $urandom};
      pc = {$urandom, $urandom};
      rd = $urandom_range(1, 31);
      we = $urandom_range(0, 1);
      nw = $urandom_range(0, 3);
      st = st_bytes(wc) != 0;
      ld = !st && rc != 0;
      n = st ? st_bytes(wc) : ld_bytes(rc);
      mis = (st || ld) && n > 1 && (o % n) != 0;
      set_op(pc, a, d, rd, we, rc, wc);
      mem_rdata = rdat;
      scnt = 0;
      if ((st || ld) && !mis) begin
        for (int c = 0; c <= nw; c++) begin
          mem_ready = (c == nw);
          #1;
          if (mem_stall === 1) scnt++;
          n_cmp++;
          if (mem_req !== 1 || mem_we !== st ||
              mem_addr !== (a - (a % 8))) begin
            n_bad++;
            $display("FAIL rnd%0d_req: req=%b we=%b addr=%h", t,
                     mem_req, mem_we, mem_addr);
          end
          if (st) begin
            n_cmp++;
            if (mem_wstrb !== ref_strb(n, o) ||
                mem_wdata !== ref_wdata(d, o)) begin
              n_bad++;
              $display("FAIL rnd%0d_st: strb=%h wd=%h want %h %h", t,
                       mem_wstrb, mem_wdata, ref_strb(n, o),
                       ref_wdata(d, o));
            end
          end
          tick();
          if (c < nw) begin
            n_cmp++;
            if (rf_wr_en_MEM !== 0 || rd_MEM !== 0) begin
              n_bad++;
              $display("FAIL rnd%0d_bubble: wen=%b rd=%0d", t,
                       rf_wr_en_MEM, rd_MEM);
            end
          end
        end
      end else begin
        nw = 0;
        mem_ready = $urandom_range(0, 1);
        #1;
        n_cmp++;
        if (mem_req !== 0 || mem_stall !== 0) begin
          n_bad++;
          $display("FAIL rnd%0d_noreq: req=%b stall=%b", t, mem_req,
                   mem_stall);
        end
        tick();
      end
      mem_ready = 0;
      set_nop();
      n_cmp++;
      if (scnt != nw) begin
        n_bad++;
        $display("FAIL rnd%0d_stalls: got %0d want %0d", t, scnt, nw);
      end
      n_cmp++;
      if (pc_MEM !== pc || alu_result_MEM !== a || rd_MEM !== rd ||
          rf_wr_en_MEM !== (we && !mis) || misalign_MEM !== mis ||
          rf_wr_sel_MEM !== 2'd1) begin
        n_bad++;
        $display("FAIL rnd%0d_mem: rd=%0d wen=%b mis=%b want %0d %b %b",
                 t, rd_MEM, rf_wr_en_MEM, misalign_MEM, rd,
                 we && !mis, mis);
      end
      n_cmp++;
      if (dm_rdata_MEM !== ((ld && !mis) ? ref_load(rc, rdat, o) : 0))
      begin
        n_bad++;
        $display("FAIL rnd%0d_dm: got %h want %h", t, dm_rdata_MEM,
                 (ld && !mis) ? ref_load(rc, rdat, o) : 64'd0);
      end
    end
  endtask

  task automatic test_reset_mid_wait;
    set_op(64'h600, 64'h6000, 0, 5'd11, 1, 7, 0);
    mem_ready = 1; mem_rdata = 64'hDEAD_BEEF_0000_0001;
    tick();
    mem_ready = 0;
    tick();
    reset = 0;
    tick();
    n_cmp++;
    if ({pc_MEM, alu_result_MEM, dm_rdata_MEM, rd_MEM, rf_wr_en_MEM,
         rf_wr_sel_MEM, misalign_MEM} !== '0) begin
      n_bad++;
      $display("FAIL rst_wait_mem: pc=%h rd=%0d wen=%b", pc_MEM, rd_MEM,
               rf_wr_en_MEM);
    end
    n_cmp++;
    if (mem_req !== 0) begin
      n_bad++;
      $display("FAIL rst_wait_req: got %b want 0", mem_req);
    end
    tick();
    reset = 1;
    set_nop();
    #1;
    n_cmp++;
    if (mem_req !== 0 || mem_stall !== 0) begin
      n_bad++;
      $display("FAIL rst_idle: req=%b stall=%b want 0 0", mem_req,
               mem_stall);
    end
    mem_ready = 1;
    tick();
    mem_ready = 0;
    n_cmp++;
    if (rf_wr_en_MEM !== 0 || dm_rdata_MEM !== 0) begin
      n_bad++;
      $display("FAIL rst_resp_ignored: wen=%b dm=%h want 0 0",
               rf_wr_en_MEM, dm_rdata_MEM);
    end
  endtask

  initial begin
    test_reset_init();
    test_sb_zero_wait();
    test_misaligned();
    test_lh_wait(0);
    test_lh_wait(1);
    test_ready_during_stall();
    test_store_priority();
    test_random();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
             n_bad);
    $finish;
  end

endmodule
